// File: rtl/ps2_key_event_queue.sv
// PS/2 scan-code sequencer: folds E0/F0 prefixes into {ext,brk,code} key events
// and buffers them in a show-ahead FIFO drained by a valid/pop handshake.
module ps2_key_event_queue #(
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3,
  parameter int KEEP_BREAK = 0,
  parameter int TIMEOUT    = 1_000_000
) (
  input  logic              Clock_50,
  input  logic              Resetn,
  input  logic [7:0]        PS2_code,
  input  logic              PS2_code_ready,
  input  logic              key_pop,
  input  logic              clear_flags,
  output logic              key_valid,
  output logic [7:0]        key_code,
  output logic              key_ext,
  output logic              key_brk,
  output logic [ADDR_W:0]   key_count,
  output logic              overflow,
  output logic              code_error
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} pfx_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_ev_t;

  pfx_t            state;
  logic            rdy_q;
  logic [TW-1:0]   tmo_cnt;
  logic            ev_vld;
  key_ev_t         ev;

  logic new_byte, is_ext, is_brk, err_byte;

  assign new_byte = PS2_code_ready & ~rdy_q;
  assign is_ext   = (state == S_EXT) || (state == S_EXT_BRK);
  assign is_brk   = (state == S_BRK) || (state == S_EXT_BRK);
  assign err_byte = new_byte && ((PS2_code == 8'h00) || (PS2_code == 8'hFF));

  // Prefix tracker; a fresh byte takes priority over the prefix timeout.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      state   <= S_IDLE;
      rdy_q   <= 1'b0;
      tmo_cnt <= '0;
      ev_vld  <= 1'b0;
      ev      <= '0;
    end else begin
      rdy_q  <= PS2_code_ready;
      ev_vld <= 1'b0;
      if (new_byte) begin
        tmo_cnt <= '0;
        case (PS2_code)
          8'hE0:        state <= is_brk ? S_EXT_BRK : S_EXT;
          8'hF0:        state <= is_ext ? S_EXT_BRK : S_BRK;
          8'h00, 8'hFF: state <= S_IDLE;
          default: begin
            state   <= S_IDLE;
            ev.ext  <= is_ext;
            ev.brk  <= is_brk;
            ev.code <= PS2_code;
            ev_vld  <= (KEEP_BREAK != 0) || !is_brk;
          end
        endcase
      end else if (state == S_IDLE) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
        state   <= S_IDLE;
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  key_ev_t           mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic              full, do_pop, do_push, drop;

  assign full    = (count == (ADDR_W+1)'(DEPTH));
  assign do_pop  = key_pop && (count != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = ev_vld && (!full || do_pop);
  assign drop    = ev_vld && full && !do_pop;

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      code_error <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= ev;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)             overflow <= 1'b1;
      else if (clear_flags) overflow <= 1'b0;
      if (err_byte)         code_error <= 1'b1;
      else if (clear_flags) code_error <= 1'b0;
    end
  end

  assign key_valid = (count != '0);
  assign key_count = count;
  assign key_code  = mem[rd_ptr].code;
  assign key_ext   = mem[rd_ptr].ext;
  assign key_brk   = mem[rd_ptr].brk;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Bench for ps2_key_event_queue: directed corner cases, then random byte streams
// checked through a scoreboard fed by a prefix-level reference model.
module tb_ps2_key_event_queue;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int TMO    = 40;

  logic clk = 1'b0, rstn = 1'b0;
  logic [7:0] code = 8'h00;
  logic rdy = 1'b0, clr = 1'b0, dir_pop = 1'b0, mon_pop = 1'b0, mon_en = 1'b0, drop_pop = 1'b0;
  logic key_pop;
  assign key_pop = mon_en ? mon_pop : dir_pop;

  logic kv, ke, kb, ovf, cerr;
  logic [7:0] kc;
  logic [ADDR_W:0] kcnt;
  logic dv, de, db, dovf, derr;
  logic [7:0] dc;
  logic [ADDR_W:0] dcnt;

  ps2_key_event_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .KEEP_BREAK(1), .TIMEOUT(TMO)) u_keep (
    .Clock_50(clk), .Resetn(rstn), .PS2_code(code), .PS2_code_ready(rdy),
    .key_pop(key_pop), .clear_flags(clr), .key_valid(kv), .key_code(kc),
    .key_ext(ke), .key_brk(kb), .key_count(kcnt), .overflow(ovf), .code_error(cerr));

  ps2_key_event_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .KEEP_BREAK(0), .TIMEOUT(TMO)) u_drop (
    .Clock_50(clk), .Resetn(rstn), .PS2_code(code), .PS2_code_ready(rdy),
    .key_pop(drop_pop), .clear_flags(clr), .key_valid(dv), .key_code(dc),
    .key_ext(de), .key_brk(db), .key_count(dcnt), .overflow(dovf), .code_error(derr));

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  logic [9:0] sb[$];
  bit m_ext, m_brk, m_err;
  int m_last = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model: prefixes accumulate, expire when the gap between bytes exceeds TMO.
  function automatic void model_byte(logic [7:0] b, int det);
    if (det - m_last > TMO) begin m_ext = 0; m_brk = 0; end
    m_last = det;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (b == 8'h00 || b == 8'hFF) m_err = 1;
      else sb.push_back({m_ext, m_brk, b});
      m_ext = 0; m_brk = 0;
    end
  endfunction

  task automatic do_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    sb.delete(); m_ext = 0; m_brk = 0; m_err = 0;
    @(negedge clk);
  endtask

  task automatic send(logic [7:0] b, int hold);
    code = b; rdy = 1'b1;
    model_byte(b, cyc + 1);
    repeat (hold) @(negedge clk);
    rdy = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop1();
    dir_pop = 1'b1;
    @(negedge clk);
    dir_pop = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Monitor: decides each pop and checks the head being taken against the scoreboard.
  initial begin
    logic [9:0] exp;
    forever begin
      @(negedge clk);
      mon_pop = 1'b0;
      if (mon_en && kv && ($urandom_range(1, 0) == 1)) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_entry: got %0h want none", {ke, kb, kc});
        end else begin
          exp = sb.pop_front();
          chk("sb_head", {22'd0, ke, kb, kc}, {22'd0, exp});
        end
        mon_pop = 1'b1;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    chk("rst_valid", kv, 0); chk("rst_count", kcnt, 0); chk("rst_code", kc, 0);
    chk("rst_ovf", ovf, 0); chk("rst_err", cerr, 0);
    do_reset();

    send(8'h1C, 1);
    chk("make_valid", kv, 1); chk("make_code", kc, 8'h1C); chk("make_ext", ke, 0);
    chk("make_brk", kb, 0); chk("make_cnt", kcnt, 1);
    chk("drop_valid", dv, 1); chk("drop_code", dc, 8'h1C); chk("drop_ext", de, 0); chk("drop_brk", db, 0);
    pop1();
    chk("pop_valid", kv, 0); chk("pop_cnt", kcnt, 0);

    send(8'hE0, 1); send(8'h75, 1);
    chk("ext_code", kc, 8'h75); chk("ext_ext", ke, 1); chk("ext_brk", kb, 0); chk("ext_cnt", kcnt, 1);
    chk("drop_cnt2", dcnt, 2);
    pop1();

    send(8'hE0, 1); send(8'hF0, 1); send(8'h75, 1);
    chk("eb_code", kc, 8'h75); chk("eb_ext", ke, 1); chk("eb_brk", kb, 1); chk("eb_cnt", kcnt, 1);
    chk("drop_brk_dropped", dcnt, 2);
    pop1();

    send(8'hF0, 1);
    repeat (TMO + 5) @(negedge clk);
    send(8'h1B, 1);
    chk("tmo_code", kc, 8'h1B); chk("tmo_brk", kb, 0); chk("tmo_ext", ke, 0);
    chk("drop_cnt3", dcnt, 3);
    pop1();

    send(8'hFF, 1);
    chk("err_set", cerr, 1); chk("err_cnt", kcnt, 0); chk("drop_err", derr, 1);
    pulse_clr();
    chk("err_clr", cerr, 0);

    send(8'h2A, 100);
    chk("held_cnt", kcnt, 1); chk("held_code", kc, 8'h2A);
    pop1();

    for (int i = 0; i <= DEPTH; i++) send(8'h10 + 8'(i), 1);
    chk("ovf_cnt", kcnt, DEPTH); chk("ovf_flag", ovf, 1); chk("ovf_head", kc, 8'h10);
    chk("drop_ovf", dovf, 1);
    pulse_clr();
    chk("ovf_clr", ovf, 0);

    // Push of 0x30 lands on the same edge as a pop of the full FIFO.
    code = 8'h30; rdy = 1'b1;
    @(negedge clk);
    dir_pop = 1'b1;
    @(negedge clk);
    dir_pop = 1'b0; rdy = 1'b0;
    @(negedge clk);
    chk("fullpp_cnt", kcnt, DEPTH); chk("fullpp_ovf", ovf, 0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("wrap_order", kc, (i < DEPTH - 1) ? 8'h11 + 8'(i) : 8'h30);
      pop1();
    end
    chk("wrap_empty", kcnt, 0);

    send(8'hE0, 1);
    do_reset();
    send(8'h75, 1);
    chk("midrst_code", kc, 8'h75); chk("midrst_ext", ke, 0); chk("midrst_cnt", kcnt, 1);

    do_reset();
    mon_en = 1'b1;
    for (int n = 0; n < 300; n++) begin
      int w, r;
      logic [7:0] b;
      w = 0;
      while (sb.size() >= DEPTH - 1 && w < 300) begin @(negedge clk); w++; end
      if (w >= 300) begin total++; bad++; $display("FAIL backpressure: got stuck want drain"); end
      r = $urandom_range(99, 0);
      if (r < 20) b = 8'hE0;
      else if (r < 35) b = 8'hF0;
      else if (r < 39) b = (r[0]) ? 8'hFF : 8'h00;
      else b = 8'($urandom_range(8'hDF, 1));
      send(b, $urandom_range(4, 1));
      if ($urandom_range(9, 0) == 0) repeat (TMO + 10) @(negedge clk);
      else repeat ($urandom_range(6, 0)) @(negedge clk);
    end
    begin
      int w;
      w = 0;
      while ((sb.size() != 0 || kv) && w < 1000) begin @(negedge clk); w++; end
      if (w >= 1000) begin total++; bad++; $display("FAIL drain: got %0d left want 0", sb.size()); end
    end
    chk("rand_cnt", kcnt, 0); chk("rand_ovf", ovf, 0); chk("rand_err", cerr, m_err);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
